// File: rtl/vend_credit_fsm.sv
// Vending controller: accumulates nickel/dime/quarter credit, vends one of N_PROD
// products at a fixed price and pays change back one nickel at a time.
module vend_credit_fsm #(
  parameter int PRICE_UNITS = 9,
  parameter int MAX_UNITS   = 13,
  parameter int N_PROD      = 2,
  parameter int CW          = 5,
  parameter int CHANGE_GAP  = 2
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              ni,
  input  logic              di,
  input  logic              qu,
  input  logic              cancel,
  input  logic [N_PROD-1:0] sel,
  output logic [N_PROD-1:0] give,
  output logic              change,
  output logic              coin_reject,
  output logic [CW-1:0]     credit,
  output logic              busy
);

  localparam int SW = CW + 1;
  localparam int GW = (CHANGE_GAP > 2) ? $clog2(CHANGE_GAP) : 1;
  localparam logic [CW-1:0] PRICE_CW   = CW'(PRICE_UNITS);
  localparam logic [SW-1:0] MAX_SW     = SW'(MAX_UNITS);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(CHANGE_GAP - 1);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  state_t            state_r;
  logic [CW-1:0]     credit_r;
  logic [N_PROD-1:0] give_r;
  logic              change_r;
  logic              coin_reject_r;
  logic              busy_r;
  logic [GW-1:0]     gap_r;

  logic [2:0]        coin_val_s;
  logic              coin_s;
  logic [SW-1:0]     sum_s;
  logic              fits_s;
  logic              has_credit_s;
  logic              can_buy_s;
  logic [N_PROD-1:0] pick_s;
  logic              found_s;

  // Coin decode (highest value wins) and one-bit-wider overflow check
  always_comb begin
    coin_val_s = 3'd0;
    if (qu) begin
      coin_val_s = 3'd5;
    end else if (di) begin
      coin_val_s = 3'd2;
    end else if (ni) begin
      coin_val_s = 3'd1;
    end else begin
      coin_val_s = 3'd0;
    end
    coin_s       = (coin_val_s != 3'd0);
    sum_s        = {1'b0, credit_r} + SW'(coin_val_s);
    fits_s       = (sum_s <= MAX_SW);
    has_credit_s = (credit_r != {CW{1'b0}});
    can_buy_s    = (credit_r >= PRICE_CW);
  end

  // Lowest-index product among the requested ones
  always_comb begin
    pick_s  = {N_PROD{1'b0}};
    found_s = 1'b0;
    for (int i = 0; i < N_PROD; i++) begin
      if (sel[i] && !found_s) begin
        pick_s[i] = 1'b1;
        found_s   = 1'b1;
      end else begin
        pick_s[i] = 1'b0;
      end
    end
  end

  // Controller state machine with registered outputs
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_r       <= ACCUM;
      credit_r      <= {CW{1'b0}};
      give_r        <= {N_PROD{1'b0}};
      change_r      <= 1'b0;
      coin_reject_r <= 1'b0;
      busy_r        <= 1'b0;
      gap_r         <= {GW{1'b0}};
    end else begin
      give_r        <= {N_PROD{1'b0}};
      change_r      <= 1'b0;
      coin_reject_r <= 1'b0;
      case (state_r)
        ACCUM: begin
          if (cancel && has_credit_s) begin
            state_r       <= CHANGE;
            busy_r        <= 1'b1;
            gap_r         <= {GW{1'b0}};
            coin_reject_r <= coin_s;
          end else if ((sel != {N_PROD{1'b0}}) && can_buy_s) begin
            give_r        <= pick_s;
            credit_r      <= credit_r - PRICE_CW;
            state_r       <= VEND;
            busy_r        <= 1'b1;
            coin_reject_r <= coin_s;
          end else if (coin_s) begin
            if (fits_s) begin
              credit_r <= sum_s[CW-1:0];
            end else begin
              coin_reject_r <= 1'b1;
            end
          end
        end
        VEND: begin
          coin_reject_r <= coin_s;
          gap_r         <= {GW{1'b0}};
          if (has_credit_s) begin
            state_r <= CHANGE;
          end else begin
            state_r <= ACCUM;
            busy_r  <= 1'b0;
          end
        end
        CHANGE: begin
          coin_reject_r <= coin_s;
          if (!has_credit_s) begin
            state_r <= ACCUM;
            busy_r  <= 1'b0;
          end else if (gap_r == {GW{1'b0}}) begin
            change_r <= 1'b1;
            credit_r <= credit_r - CW'(1);
            gap_r    <= GAP_RELOAD;
          end else begin
            gap_r <= gap_r - GW'(1);
          end
        end
        default: begin
          state_r <= ACCUM;
          busy_r  <= 1'b0;
          gap_r   <= {GW{1'b0}};
        end
      endcase
    end
  end

  assign give        = give_r;
  assign change      = change_r;
  assign coin_reject = coin_reject_r;
  assign credit      = credit_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Scoreboard bench for vend_credit_fsm: a schedule-based reference model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_vend_credit_fsm;

  localparam int P    = 9;
  localparam int MAXU = 13;
  localparam int N    = 2;
  localparam int CW   = 5;
  localparam int G    = 2;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic          ni = 1'b0, di = 1'b0, qu = 1'b0, cancel = 1'b0;
  logic [N-1:0]  sel = '0;
  logic [N-1:0]  give;
  logic          change, coin_reject, busy;
  logic [CW-1:0] credit;

  vend_credit_fsm #(
    .PRICE_UNITS(P), .MAX_UNITS(MAXU), .N_PROD(N), .CW(CW), .CHANGE_GAP(G)
  ) dut (
    .CLK(CLK), .rst(rst), .ni(ni), .di(di), .qu(qu), .cancel(cancel), .sel(sel),
    .give(give), .change(change), .coin_reject(coin_reject), .credit(credit), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [N-1:0]  give;
    logic          change;
    logic          rej;
    logic [CW-1:0] credit;
    logic          busy;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: credit plus a refund schedule (first pulse edge, pulses left,
  // edge from which the machine listens to customers again).
  int edge_n    = 0;
  int m_credit  = 0;
  int m_free_at = 0;
  int m_p0      = 0;
  int m_left    = 0;
  int m_pulses  = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (!rst && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("give",        int'(give),        int'(e.give));
      chk("change",      int'(change),      int'(e.change));
      chk("coin_reject", int'(coin_reject), int'(e.rej));
      chk("credit",      int'(credit),      int'(e.credit));
      chk("busy",        int'(busy),        int'(e.busy));
    end
  end

  task automatic step(input logic i_ni, input logic i_di, input logic i_qu,
                      input logic i_cancel, input logic [N-1:0] i_sel);
    exp_t x;
    int   v;
    int   e;
    int   idx;
    ni = i_ni; di = i_di; qu = i_qu; cancel = i_cancel; sel = i_sel;
    e  = edge_n;
    v  = i_qu ? 5 : (i_di ? 2 : (i_ni ? 1 : 0));
    x  = '0;
    if (e >= m_free_at) begin
      if (i_cancel && m_credit > 0) begin
        m_left    = m_credit;
        m_p0      = e + 1;
        m_free_at = e + 1 + (m_credit - 1) * G + 2;
        x.rej     = (v > 0);
      end else if (i_sel != '0 && m_credit >= P) begin
        idx = -1;
        for (int i = 0; i < N; i++) begin
          if (i_sel[i] && idx < 0) idx = i;
        end
        x.give[idx] = 1'b1;
        m_credit    = m_credit - P;
        if (m_credit > 0) begin
          m_left    = m_credit;
          m_p0      = e + 2;
          m_free_at = e + 2 + (m_credit - 1) * G + 2;
        end else begin
          m_free_at = e + 2;
        end
        x.rej = (v > 0);
      end else if (v > 0) begin
        if (m_credit + v <= MAXU) m_credit = m_credit + v;
        else x.rej = 1'b1;
      end
    end else begin
      x.rej = (v > 0);
      if (m_left > 0 && e >= m_p0 && ((e - m_p0) % G) == 0) begin
        x.change = 1'b1;
        m_credit--;
        m_left--;
        m_pulses++;
      end
    end
    x.credit = m_credit[CW-1:0];
    x.busy   = (e + 1 < m_free_at);
    @(posedge CLK);
    edge_n++;
    sb_q.push_back(x);
    #1;
    ni = 1'b0; di = 1'b0; qu = 1'b0; cancel = 1'b0; sel = '0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    @(posedge CLK);
    @(posedge CLK);
    #2;
    chk("reset_give",   int'(give),        0);
    chk("reset_change", int'(change),      0);
    chk("reset_reject", int'(coin_reject), 0);
    chk("reset_credit", int'(credit),      0);
    chk("reset_busy",   int'(busy),        0);
    rst = 1'b0;

    // nine nickels then buy product 0 with exact credit
    for (int k = 0; k < 9; k++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    idle(3);

    // 12 units, buy product 1, three change pulses
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    idle(10);

    // overflowing quarter refused, then nickel accepted, then refund
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle(25);

    // cancel beats select and coin in the same cycle
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'b01);
    idle(20);

    // simultaneous coins, then both products selected
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    idle(6);

    // reset in the middle of the second change pulse
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    m_pulses = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    for (int k = 0; k < 20 && m_pulses < 2; k++) idle(1);
    chk("pulse_wait", m_pulses, 2);
    @(negedge CLK);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_give",   int'(give),        0);
    chk("midrst_change", int'(change),      0);
    chk("midrst_reject", int'(coin_reject), 0);
    chk("midrst_credit", int'(credit),      0);
    chk("midrst_busy",   int'(busy),        0);
    sb_q.delete();
    @(posedge CLK);
    #1;
    rst       = 1'b0;
    m_credit  = 0;
    m_free_at = 0;
    m_left    = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(4);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      logic r_ni, r_di, r_qu, r_cancel;
      logic [N-1:0] r_sel;
      r_ni     = ($urandom_range(0, 4) == 0);
      r_di     = ($urandom_range(0, 5) == 0);
      r_qu     = ($urandom_range(0, 7) == 0);
      r_cancel = ($urandom_range(0, 40) == 0);
      r_sel    = ($urandom_range(0, 6) == 0) ? N'($urandom_range(1, 3)) : '0;
      step(r_ni, r_di, r_qu, r_cancel, r_sel);
    end
    idle(30);

    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
